// File: rtl/wb_timeout_pkg.sv
// Shared types and constants for the Wishbone timeout bridge.
package wb_timeout_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    ERR_RESP = 2'd2,
    FLUSH    = 2'd3
  } wb_to_state_e;

  localparam int STATS_W = 16;

endpackage

// File: rtl/wb_timeout_bridge.sv
// Wishbone pass-through bridge that terminates stalled accesses with ERR.
// Optional timeout statistics counter enabled by WB_TIMEOUT_STATS_EN.
module wb_timeout_bridge
  import wb_timeout_pkg::*;
#(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  // upstream (master side)
  input  logic                       m_cyc_i,
  input  logic                       m_stb_i,
  input  logic                       m_we_i,
  input  logic [WB_ADDR_WIDTH-1:0]   m_adr_i,
  input  logic [WB_DATA_WIDTH-1:0]   m_dat_w_i,
  input  logic [WB_DATA_WIDTH/8-1:0] m_sel_i,
  input  logic [2:0]                 m_cti_i,
  input  logic [1:0]                 m_bte_i,
  output logic [WB_DATA_WIDTH-1:0]   m_dat_r_o,
  output logic                       m_ack_o,
  output logic                       m_err_o,
  // downstream (target slave side)
  output logic                       s_cyc_o,
  output logic                       s_stb_o,
  output logic                       s_we_o,
  output logic [WB_ADDR_WIDTH-1:0]   s_adr_o,
  output logic [WB_DATA_WIDTH-1:0]   s_dat_w_o,
  output logic [WB_DATA_WIDTH/8-1:0] s_sel_o,
  output logic [2:0]                 s_cti_o,
  output logic [1:0]                 s_bte_o,
  input  logic [WB_DATA_WIDTH-1:0]   s_dat_r_i,
  input  logic                       s_ack_i,
  input  logic                       s_err_i,
  // status
  output logic                       timeout_o,
  output logic [STATS_W-1:0]         timeout_count_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  wb_to_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic req, resp, pass, err_st;

  assign req  = m_cyc_i & m_stb_i;
  assign resp = s_ack_i | s_err_i;

  // Request cycle counts as the first wait cycle, so ERR lands TIMEOUT_CYCLES after it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req && !resp) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT: begin
        if (!req || resp) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ERR_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ERR_RESP: begin
        state_d = FLUSH;
        cnt_d   = '0;
      end
      FLUSH: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pass   = !rst && (state_q == IDLE || state_q == WAIT);
  assign err_st = !rst && (state_q == ERR_RESP);

  assign s_cyc_o   = pass & m_cyc_i;
  assign s_stb_o   = pass & m_stb_i;
  assign s_we_o    = m_we_i;
  assign s_adr_o   = m_adr_i;
  assign s_dat_w_o = m_dat_w_i;
  assign s_sel_o   = m_sel_i;
  assign s_cti_o   = m_cti_i;
  assign s_bte_o   = m_bte_i;

  // Late slave responses outside IDLE/WAIT are swallowed here.
  assign m_dat_r_o = pass ? s_dat_r_i : '0;
  assign m_ack_o   = pass & s_ack_i;
  assign m_err_o   = err_st | (pass & s_err_i);
  assign timeout_o = err_st;

`ifdef WB_TIMEOUT_STATS_EN
  logic [STATS_W-1:0] stats_q, stats_d;

  always_comb begin
    stats_d = stats_q;
    if (state_q == ERR_RESP && stats_q != {STATS_W{1'b1}})
      stats_d = stats_q + STATS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) stats_q <= '0;
    else     stats_q <= stats_d;
  end

  assign timeout_count_o = stats_q;
`else
  assign timeout_count_o = '0;
`endif

endmodule

// File: tb/tb_wb_timeout_bridge.sv
// Scoreboard bench for wb_timeout_bridge with TIMEOUT_CYCLES=8.
module tb_wb_timeout_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  logic m_cyc_i, m_stb_i, m_we_i;
  logic [AW-1:0]   m_adr_i;
  logic [DW-1:0]   m_dat_w_i;
  logic [DW/8-1:0] m_sel_i;
  logic [2:0]      m_cti_i;
  logic [1:0]      m_bte_i;
  logic [DW-1:0]   m_dat_r_o;
  logic            m_ack_o, m_err_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_w_o;
  logic [DW/8-1:0] s_sel_o;
  logic [2:0]      s_cti_o;
  logic [1:0]      s_bte_o;
  logic [DW-1:0]   s_dat_r_i;
  logic            s_ack_i, s_err_i;
  logic            timeout_o;
  logic [15:0]     timeout_count_o;

  wb_timeout_bridge #(
    .WB_ADDR_WIDTH (AW),
    .WB_DATA_WIDTH (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .m_cyc_i        (m_cyc_i),
    .m_stb_i        (m_stb_i),
    .m_we_i         (m_we_i),
    .m_adr_i        (m_adr_i),
    .m_dat_w_i      (m_dat_w_i),
    .m_sel_i        (m_sel_i),
    .m_cti_i        (m_cti_i),
    .m_bte_i        (m_bte_i),
    .m_dat_r_o      (m_dat_r_o),
    .m_ack_o        (m_ack_o),
    .m_err_o        (m_err_o),
    .s_cyc_o        (s_cyc_o),
    .s_stb_o        (s_stb_o),
    .s_we_o         (s_we_o),
    .s_adr_o        (s_adr_o),
    .s_dat_w_o      (s_dat_w_o),
    .s_sel_o        (s_sel_o),
    .s_cti_o        (s_cti_o),
    .s_bte_o        (s_bte_o),
    .s_dat_r_i      (s_dat_r_i),
    .s_ack_i        (s_ack_i),
    .s_err_i        (s_err_i),
    .timeout_o      (timeout_o),
    .timeout_count_o(timeout_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] dat;
    int          cyc;
  } resp_t;

  resp_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    exp_to   = 0;

  function automatic logic [15:0] exp_stats();
`ifdef WB_TIMEOUT_STATS_EN
    return 16'(exp_to);
`else
    return 16'h0;
`endif
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    m_cyc_i = 1'b0; m_stb_i = 1'b0; s_ack_i = 1'b0; s_err_i = 1'b0;
  endtask

  // One beat: request driven now (cycle 0); slave acks at cycle ack_at (<0 = never).
  task automatic beat(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                      input logic [2:0] cti, input int ack_at, input logic [31:0] rdat);
    resp_t e, o;
    bit    seen = 1'b0;
    int    at   = 0;
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = we; m_adr_i = adr;
    m_dat_w_i = wdat; m_sel_i = 4'hF; m_cti_i = cti; m_bte_i = 2'b00;
    e.err = !(ack_at >= 0 && ack_at <= TO - 1);
    e.dat = e.err ? 32'h0 : rdat;
    e.cyc = e.err ? TO : ack_at;
    sb.push_back(e);
    for (int i = 0; i < 20; i++) begin
      s_ack_i   = (i == ack_at);
      s_dat_r_i = (i == ack_at) ? rdat : 32'hA5A5_A5A5;
      #1;
      if (i == 0) begin
        n_checks++;
        if (s_cyc_o !== 1'b1 || s_adr_o !== adr || s_dat_w_o !== wdat ||
            s_we_o !== we || s_cti_o !== cti) begin
          n_fail++;
          $display("FAIL passthru: s_cyc=%b adr=%h dat=%h we=%b cti=%b expected 1 %h %h %b %b",
                   s_cyc_o, s_adr_o, s_dat_w_o, s_we_o, s_cti_o, 1'b1, adr, wdat, we, cti);
        end
      end
      if (m_ack_o || m_err_o) begin
        seen = 1'b1;
        at   = i;
        break;
      end
      n_checks++;
      if (timeout_o !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_quiet: cycle %0d timeout_o=%b expected 0", i, timeout_o);
      end
      next_cyc();
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL resp_budget: no m.ACK/m.ERR within 20 cycles, expected one at cycle %0d", e.cyc);
      void'(sb.pop_front());
    end else begin
      o = sb.pop_front();
      if (m_err_o !== o.err || m_ack_o !== !o.err || m_dat_r_o !== o.dat ||
          at != o.cyc || timeout_o !== o.err) begin
        n_fail++;
        $display("FAIL resp: err=%b ack=%b dat=%h cyc=%0d to=%b expected err=%b ack=%b dat=%h cyc=%0d to=%b",
                 m_err_o, m_ack_o, m_dat_r_o, at, timeout_o, o.err, !o.err, o.dat, o.cyc, o.err);
      end
      if (o.err) begin
        n_checks++;
        if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin
          n_fail++;
          $display("FAIL err_cyc_gate: s_cyc=%b s_stb=%b expected 0 0", s_cyc_o, s_stb_o);
        end
      end
    end
    next_cyc();
    s_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_cyc_i = 1'b1; m_stb_i = 1'b1; s_ack_i = 1'b1; s_err_i = 1'b1;
    next_cyc();
    n_checks++;
    if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || m_ack_o !== 1'b0 ||
        m_err_o !== 1'b0 || timeout_o !== 1'b0 || timeout_count_o !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: s_cyc=%b s_stb=%b ack=%b err=%b to=%b cnt=%0d expected all 0",
               s_cyc_o, s_stb_o, m_ack_o, m_err_o, timeout_o, timeout_count_o);
    end
    rst = 1'b0;
    bus_idle();
    next_cyc();
  endtask

  task automatic test_read();
    beat(1'b0, 32'h0000_1000, 32'h0, 3'b000, 3, 32'hDEADBEEF);
    bus_idle();
    n_checks++;
    if (timeout_count_o !== exp_stats()) begin
      n_fail++;
      $display("FAIL read_stats: count=%0d expected %0d", timeout_count_o, exp_stats());
    end
    next_cyc();
  endtask

  task automatic test_timeout();
    beat(1'b1, 32'h0000_2000, 32'h1234_5678, 3'b000, -1, 32'h0);
    exp_to++;
    // FLUSH cycle, master still holding the request
    #1;
    n_checks++;
    if (s_cyc_o !== 1'b0 || m_err_o !== 1'b0 || timeout_o !== 1'b0 ||
        timeout_count_o !== exp_stats()) begin
      n_fail++;
      $display("FAIL flush_cycle: s_cyc=%b err=%b to=%b cnt=%0d expected 0 0 0 %0d",
               s_cyc_o, m_err_o, timeout_o, timeout_count_o, exp_stats());
    end
    bus_idle();
    next_cyc();
  endtask

  task automatic test_expiry_ack();
    beat(1'b0, 32'h0000_3000, 32'h0, 3'b000, TO - 1, 32'hCAFE_F00D);
    bus_idle();
    n_checks++;
    if (timeout_count_o !== exp_stats()) begin
      n_fail++;
      $display("FAIL expiry_stats: count=%0d expected %0d", timeout_count_o, exp_stats());
    end
    next_cyc();
  endtask

  task automatic test_burst();
    for (int b = 0; b < 4; b++)
      beat(1'b0, 32'h0000_4000 + 32'(b * 4), 32'h0, (b == 3) ? 3'b111 : 3'b010,
           6, 32'h1111_0000 + 32'(b));
    bus_idle();
    n_checks++;
    if (timeout_count_o !== exp_stats() || sb.size() != 0) begin
      n_fail++;
      $display("FAIL burst_stats: count=%0d sb=%0d expected %0d 0",
               timeout_count_o, sb.size(), exp_stats());
    end
    next_cyc();
  endtask

  // Late ACKs in ERR_RESP and FLUSH are dropped; the held request then re-issues.
  task automatic test_late_ack();
    beat(1'b0, 32'h0000_5000, 32'h0, 3'b000, TO, 32'hBAAD_BAAD);
    exp_to++;
    s_ack_i = 1'b1; s_dat_r_i = 32'h7777_7777;
    #1;
    n_checks++;
    if (m_ack_o !== 1'b0 || m_err_o !== 1'b0 || s_cyc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_late_ack: ack=%b err=%b s_cyc=%b expected 0 0 0", m_ack_o, m_err_o, s_cyc_o);
    end
    next_cyc();
    beat(1'b0, 32'h0000_5000, 32'h0, 3'b000, 0, 32'h5555_AAAA);
    bus_idle();
    n_checks++;
    if (timeout_count_o !== exp_stats()) begin
      n_fail++;
      $display("FAIL late_stats: count=%0d expected %0d", timeout_count_o, exp_stats());
    end
    next_cyc();
  endtask

  task automatic test_back_to_back();
    beat(1'b0, 32'h0000_6000, 32'h0, 3'b000, 0, 32'h0101_0101);
    beat(1'b1, 32'h0000_6004, 32'hFEED_0002, 3'b000, 0, 32'h0202_0202);
    bus_idle();
    next_cyc();
  endtask

  task automatic test_reset_in_wait();
    bit err_seen = 1'b0;
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b0; m_adr_i = 32'h0000_7000;
    m_cti_i = 3'b000; s_ack_i = 1'b0;
    for (int i = 0; i < 5; i++) next_cyc();
    rst = 1'b1;
    #1;
    n_checks++;
    if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || m_err_o !== 1'b0 || timeout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wait: s_cyc=%b s_stb=%b err=%b to=%b expected 0 0 0 0",
               s_cyc_o, s_stb_o, m_err_o, timeout_o);
    end
    next_cyc();
    rst = 1'b0;
    bus_idle();
    exp_to = 0;
    n_checks++;
    if (timeout_count_o !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_stats: count=%0d expected 0", timeout_count_o);
    end
    for (int i = 0; i < 12; i++) begin
      #1;
      if (m_err_o === 1'b1) err_seen = 1'b1;
      next_cyc();
    end
    n_checks++;
    if (err_seen) begin
      n_fail++;
      $display("FAIL rst_no_err: m.ERR seen=%b after reset expected 0", err_seen);
    end
    // fresh access must time out after the full budget, proving the counter cleared
    beat(1'b0, 32'h0000_7100, 32'h0, 3'b000, -1, 32'h0);
    exp_to++;
    bus_idle();
    next_cyc();
    n_checks++;
    if (timeout_count_o !== exp_stats()) begin
      n_fail++;
      $display("FAIL post_rst_stats: count=%0d expected %0d", timeout_count_o, exp_stats());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0; m_adr_i = '0;
    m_dat_w_i = '0; m_sel_i = '0; m_cti_i = '0; m_bte_i = '0;
    s_dat_r_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
    next_cyc();
    test_reset();
    test_read();
    test_timeout();
    test_expiry_ack();
    test_burst();
    test_late_ack();
    test_back_to_back();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_timeout_bridge.md
WB_TIMEOUT_BRIDGE -- requirements
Module: wb_timeout_bridge

Interface
REQ-001 Parameter: WB_ADDR_WIDTH, 32, address width of both ports.
REQ-002 Parameter: WB_DATA_WIDTH, 32, data width of both ports; must be a multiple of 8.
REQ-003 Parameter: TIMEOUT_CYCLES, 256, number of cycles without a response before an access is terminated; must be ≥2.
REQ-004 clk  input  1  the block's one clock.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 m  wb_if.slave  WB params  upstream port, driven by one interconnect slave port.
REQ-007 s  wb_if.master  WB params  downstream port, drives the target slave.
REQ-008 timeout_o  output  1  one-cycle pulse per terminated access.
REQ-009 timeout_count_o  output  16  number of timeouts seen; see Configuration.

Function
REQ-010 The FSM SHALL have 4 states:
- IDLE: no access outstanding.
- WAIT: access outstanding.
- ERR_RESP: block returns ERR upstream.
- FLUSH: one-cycle gap before returning to IDLE.
REQ-011 In IDLE and WAIT, all request signals (ADR, CTI, BTE, DAT_W, CYC, SEL, STB, WE) SHALL pass m→s combinationally, with 0 latency.
REQ-012 In IDLE and WAIT, DAT_R, ACK and ERR SHALL pass s→m combinationally.
REQ-013 IDLE→WAIT SHALL occur when m.CYC&m.STB is high and s.ACK|s.ERR is low. An access acknowledged in the same cycle stays in IDLE.
REQ-014 The wait counter SHALL be $clog2(TIMEOUT_CYCLES) bits wide.
- It is 0 in IDLE.
- It increments each WAIT cycle with no s.ACK|s.ERR.
- It clears on any s.ACK|s.ERR, so each burst beat gets a fresh timeout.
REQ-015 WAIT→IDLE SHALL occur when s.ACK|s.ERR is high and the m.CYC&m.STB of the next beat is low.
REQ-016 If m drops CYC in WAIT, the block SHALL go to IDLE and clear the counter. This is an abort, not a timeout.
REQ-017 WAIT→ERR_RESP SHALL occur when the counter equals TIMEOUT_CYCLES-1 and no response arrives that cycle. The first m.ERR therefore occurs TIMEOUT_CYCLES cycles after the request cycle.
REQ-018 If s.ACK or s.ERR arrives in the expiry cycle, the slave response SHALL win: it passes through and no timeout occurs.
REQ-019 In ERR_RESP the block SHALL drive:
- m.ERR=1, m.ACK=0, m.DAT_R=0;
- s.CYC=0, s.STB=0;
- timeout_o=1.
ERR_RESP lasts exactly one cycle, then goes to FLUSH.
REQ-020 In FLUSH the block SHALL drive s.CYC=0, s.STB=0, m.ACK=0 and m.ERR=0. FLUSH lasts exactly one cycle, then goes to IDLE.
REQ-021 A late s.ACK or s.ERR arriving in ERR_RESP or FLUSH SHALL be discarded and never reach m.
REQ-022 A master request held through ERR_RESP and FLUSH SHALL be forwarded as a new access once the block is back in IDLE.

Reset
REQ-023 While rst=1, the block SHALL drive s.CYC=0, s.STB=0, m.ACK=0, m.ERR=0 and timeout_o=0, regardless of inputs.
REQ-024 On the first clk edge with rst=1, the block SHALL load state=IDLE, counter=0 and timeout_count_o=0.
REQ-025 Reset asserted during WAIT, ERR_RESP or FLUSH SHALL abandon the access, with no ERR pulse after reset deasserts.

Configuration
REQ-026 With WB_TIMEOUT_STATS_EN defined:
- timeout_count_o SHALL increment by 1 on each ERR_RESP cycle;
- it SHALL saturate at 16'hFFFF.
REQ-027 With WB_TIMEOUT_STATS_EN undefined:
- timeout_count_o SHALL be constant 0;
- no counter register SHALL be synthesised.

Structure
REQ-028 The FSM state enum (IDLE, WAIT, ERR_RESP, FLUSH) and the stats counter width constant (16) SHALL live in the shared package wb_timeout_pkg.
REQ-029 The block SHALL be one flat module, with no sub-module; the FSM and counters are too small to justify splitting.

Verification
All scenarios use TIMEOUT_CYCLES=8 and WB_TIMEOUT_STATS_EN defined.
REQ-030 Read; slave ACKs 3 cycles after STB with DAT_R=32'hDEADBEEF → m.ACK in the same cycle, DAT_R=32'hDEADBEEF, timeout_o stays 0.
REQ-031 Write; slave never responds → m.ERR=1 for one cycle exactly 8 cycles after the request cycle. Also s.CYC=0 in that cycle and the next, timeout_o pulses once, timeout_count_o=1.
REQ-032 Slave ACKs exactly in cycle 7 (the expiry cycle) → ACK passes through, no ERR, timeout_count_o unchanged.
REQ-033 4-beat incrementing burst (CTI=3'b010); each beat ACKed after 6 cycles → all 4 beats ACKed, no timeout.
REQ-034 Slave ACK asserted during FLUSH after a timeout → m.ACK stays 0; the next access completes normally.
REQ-035 rst=1 at WAIT cycle 5, held 1 cycle → s.CYC=0 and m.ERR=0 during reset, state=IDLE and counter=0 afterwards, no ERR pulse later.
